// File: rtl/serdes_pkg.sv
// Shared receive-path constants: K28.5 codes, 7-bit comma patterns
// and the word-aligner state encoding.
package serdes_pkg;

   localparam logic [9:0] K28_5_RDN = 10'b0011111010;
   localparam logic [9:0] K28_5_RDP = 10'b1100000101;

   localparam logic [6:0] COMMA_P7 = 7'b0011111;
   localparam logic [6:0] COMMA_N7 = 7'b1100000;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      PEND   = 2'd1,
      LOCKED = 2'd2
   } align_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/comma_detect.sv
// Combinational comma recogniser on a 10-bit window (sr -> comma).
// COMMA_ANY_EN: match the 7-bit comma prefix (K28.1/5/7); else K28.5 only.
module comma_detect
   import serdes_pkg::*;
(
   input  logic [9:0] sr,
   output logic       comma
);

`ifdef COMMA_ANY_EN
   logic unused_low;

   assign unused_low = ^sr[2:0];
   assign comma = (sr[9:3] == COMMA_P7) ||
                  (sr[9:3] == COMMA_N7);
`else
   assign comma = (sr == K28_5_RDN) ||
                  (sr == K28_5_RDP);
`endif

endmodule

// File: rtl/comma_aligner.sv
// Serial-to-10b word aligner with HUNT/PEND/LOCKED sync state machine.
// Ports: BitCLK, Reset (async low), RxSerial in; RxParallel_10,
// RxDataValid, RxComma, RxLocked out. Option macro: COMMA_ANY_EN.
module comma_aligner
   import serdes_pkg::*;
#(
   parameter int LOCK_CNT = 3,
   parameter int LOSS_CNT = 4
)
(
   input  logic       BitCLK,
   input  logic       Reset,
   input  logic       RxSerial,
   output logic [9:0] RxParallel_10,
   output logic       RxDataValid,
   output logic       RxComma,
   output logic       RxLocked
);

   localparam int CW = $clog2(max_int(LOCK_CNT, LOSS_CNT) + 1);
   localparam logic [CW-1:0] LOCK_V = CW'(LOCK_CNT);
   localparam logic [CW-1:0] LOSS_V = CW'(LOSS_CNT);
   localparam logic [CW-1:0] ONE    = CW'(1);

   align_state_t state, state_nx;

   logic [9:0]    sr;
   logic [3:0]    cnt, cnt_nx;
   logic [CW-1:0] good, good_nx, good_inc;
   logic [CW-1:0] bad, bad_nx, bad_inc;
   logic          comma;
   logic          aligned;
   logic          emit;

   comma_detect u_det (
      .sr    (sr),
      .comma (comma)
   );

   assign aligned  = (cnt == 4'd9);
   assign good_inc = (good >= LOCK_V) ? good : good + ONE;
   assign bad_inc  = (bad >= LOSS_V) ? bad : bad + ONE;

   always_comb begin
      state_nx = state;
      cnt_nx   = aligned ? 4'd0 : cnt + 4'd1;
      good_nx  = good;
      bad_nx   = bad;
      emit     = 1'b0;
      unique case (state)
         HUNT: begin
            if (comma) begin
               emit    = 1'b1;
               cnt_nx  = 4'd0;
               good_nx = ONE;
               // a single comma is enough when LOCK_CNT is 1
               if (ONE >= LOCK_V) begin
                  state_nx = LOCKED;
                  bad_nx   = '0;
               end else begin
                  state_nx = PEND;
               end
            end
         end
         PEND: begin
            if (aligned) begin
               emit = 1'b1;
               if (comma) begin
                  good_nx = good_inc;
                  if (good_inc >= LOCK_V) begin
                     state_nx = LOCKED;
                     bad_nx   = '0;
                  end
               end
            end else if (comma) begin
               // boundary was wrong: restart on this comma
               emit    = 1'b1;
               cnt_nx  = 4'd0;
               good_nx = ONE;
            end
         end
         LOCKED: begin
            if (aligned) begin
               emit = 1'b1;
               if (comma) begin
                  bad_nx = '0;
               end
            end else if (comma) begin
               // boundary stays frozen; only count the slip
               bad_nx = bad_inc;
               if (bad_inc >= LOSS_V) begin
                  state_nx = HUNT;
               end
            end
         end
         default: begin
            state_nx = HUNT;
         end
      endcase
   end

   always_ff @(posedge BitCLK or negedge Reset) begin
      if (!Reset) begin
         state         <= HUNT;
         sr            <= '0;
         cnt           <= '0;
         good          <= '0;
         bad           <= '0;
         RxParallel_10 <= '0;
         RxDataValid   <= 1'b0;
         RxComma       <= 1'b0;
      end else begin
         state       <= state_nx;
         sr          <= {sr[8:0], RxSerial};
         cnt         <= cnt_nx;
         good        <= good_nx;
         bad         <= bad_nx;
         RxDataValid <= emit;
         if (emit) begin
            RxParallel_10 <= sr;
            RxComma       <= comma;
         end
      end
   end

   assign RxLocked = (state == LOCKED);

endmodule

// File: tb/tb_comma_aligner.sv
// Directed table-driven bench for comma_aligner.
// Words are shifted in MSB (bit a) first; strobes seen per vector are checked.
module tb_comma_aligner;

   logic       BitCLK;
   logic       Reset;
   logic       RxSerial;
   logic [9:0] RxParallel_10;
   logic       RxDataValid;
   logic       RxComma;
   logic       RxLocked;

   comma_aligner dut (
      .BitCLK        (BitCLK),
      .Reset         (Reset),
      .RxSerial      (RxSerial),
      .RxParallel_10 (RxParallel_10),
      .RxDataValid   (RxDataValid),
      .RxComma       (RxComma),
      .RxLocked      (RxLocked)
   );

   initial BitCLK = 1'b0;
   always #5 BitCLK = ~BitCLK;

`ifdef COMMA_ANY_EN
   localparam int ANY = 1;
`else
   localparam int ANY = 0;
`endif

   localparam logic [9:0] K  = 10'b0011111010;
   localparam logic [9:0] D  = 10'b0001100010;
   localparam logic [9:0] A  = 10'b1010101010;
   localparam logic [9:0] M1 = 10'b1010011111;
   localparam logic [9:0] M2 = 10'b0101010101;
   localparam logic [9:0] K1 = 10'b0011111001;

   typedef struct {
      logic [9:0] tx;
      int         nb;
      int         en;
      logic [9:0] ew;
      logic       ec;
      logic       el;
      logic       eend;
   } vec_t;

   vec_t tbl [34];

   int total;
   int nbad;
   int n_str;
   logic [9:0] last_w;
   logic       last_c;
   logic       last_l;

   function automatic vec_t mk(input logic [9:0] tx, input int nb,
                               input int en, input logic [9:0] ew,
                               input logic ec, input logic el,
                               input logic eend);
      vec_t v;
      v.tx = tx; v.nb = nb; v.en = en; v.ew = ew;
      v.ec = ec; v.el = el; v.eend = eend;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         nbad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      RxSerial = b;
      @(posedge BitCLK);
      @(negedge BitCLK);
      if (RxDataValid) begin
         n_str++;
         last_w = RxParallel_10;
         last_c = RxComma;
         last_l = RxLocked;
      end
   endtask

   task automatic apply(input vec_t v, input string nm);
      n_str = 0;
      for (int i = v.nb - 1; i >= 0; i--) send_bit(v.tx[i]);
      chk({nm, "_nstrobe"}, n_str, v.en);
      if (v.en > 0) begin
         chk({nm, "_word"}, int'(last_w), int'(v.ew));
         chk({nm, "_comma"}, int'(last_c), int'(v.ec));
         chk({nm, "_lock_at_strobe"}, int'(last_l), int'(v.el));
      end
      chk({nm, "_lock_end"}, int'(RxLocked), int'(v.eend));
   endtask

   initial begin
      total    = 0;
      nbad     = 0;
      n_str    = 0;
      last_w   = '0;
      last_c   = 1'b0;
      last_l   = 1'b0;
      Reset    = 1'b0;
      RxSerial = 1'b0;

      // acquisition: idle, 3 x K28.5, D.8.4, D.21.5
      tbl[0]  = mk(10'b000, 3, 0, 0, 0, 0, 0);
      tbl[1]  = mk(K,  10, 0, 0, 0, 0, 0);
      tbl[2]  = mk(K,  10, 1, K,  1, 0, 0);
      tbl[3]  = mk(K,  10, 1, K,  1, 0, 0);
      tbl[4]  = mk(D,  10, 1, K,  1, 1, 1);
      tbl[5]  = mk(A,  10, 1, D,  0, 1, 1);
      // single slip, aligned comma, three slips: lock holds
      tbl[6]  = mk(M1, 10, 1, A,  0, 1, 1);
      tbl[7]  = mk(M2, 10, 1, M1, 0, 1, 1);
      tbl[8]  = mk(K,  10, 1, M2, 0, 1, 1);
      tbl[9]  = mk(M1, 10, 1, K,  1, 1, 1);
      tbl[10] = mk(M2, 10, 1, M1, 0, 1, 1);
      tbl[11] = mk(M1, 10, 1, M2, 0, 1, 1);
      tbl[12] = mk(M2, 10, 1, M1, 0, 1, 1);
      tbl[13] = mk(M1, 10, 1, M2, 0, 1, 1);
      tbl[14] = mk(M2, 10, 1, M1, 0, 1, 1);
      tbl[15] = mk(K,  10, 1, M2, 0, 1, 1);
      // four slips with no aligned comma: loss of sync
      tbl[16] = mk(M1, 10, 1, K,  1, 1, 1);
      tbl[17] = mk(M2, 10, 1, M1, 0, 1, 1);
      tbl[18] = mk(M1, 10, 1, M2, 0, 1, 1);
      tbl[19] = mk(M2, 10, 1, M1, 0, 1, 1);
      tbl[20] = mk(M1, 10, 1, M2, 0, 1, 1);
      tbl[21] = mk(M2, 10, 1, M1, 0, 1, 1);
      tbl[22] = mk(M1, 10, 1, M2, 0, 1, 1);
      tbl[23] = mk(M2, 10, 1, M1, 0, 1, 0);
      tbl[24] = mk(A,  10, 0, 0,  0, 0, 0);
      // reacquire at new offset, then realign by 5 bits, relock
      tbl[25] = mk(10'b1010, 4, 0, 0, 0, 0, 0);
      tbl[26] = mk(K,  10, 0, 0,  0, 0, 0);
      tbl[27] = mk(A,  10, 1, K,  1, 0, 0);
      tbl[28] = mk(10'b10101, 5, 1, A, 0, 0, 0);
      tbl[29] = mk(K,  10, 1, 10'b1010100111, 0, 0, 0);
      tbl[30] = mk(K,  10, 1, K,  1, 0, 0);
      tbl[31] = mk(K,  10, 1, K,  1, 0, 0);
      tbl[32] = mk(A,  10, 1, K,  1, 1, 1);
      tbl[33] = mk(A,  10, 1, A,  0, 1, 1);

      // reset held low with toggling input
      @(negedge BitCLK);
      n_str = 0;
      for (int i = 0; i < 15; i++) send_bit(i[0]);
      chk("rst_nstrobe", n_str, 0);
      chk("rst_word", int'(RxParallel_10), 0);
      chk("rst_comma", int'(RxComma), 0);
      chk("rst_locked", int'(RxLocked), 0);
      chk("rst_valid", int'(RxDataValid), 0);
      Reset = 1'b1;

      for (int i = 0; i < 34; i++) begin
         apply(tbl[i], $sformatf("v%0d", i));
      end

      // async reset while a strobe is high
      send_bit(1'b1);
      chk("pre_rst_valid", int'(RxDataValid), 1);
      Reset = 1'b0;
      #1;
      chk("mid_rst_valid", int'(RxDataValid), 0);
      chk("mid_rst_word", int'(RxParallel_10), 0);
      chk("mid_rst_locked", int'(RxLocked), 0);
      chk("mid_rst_comma", int'(RxComma), 0);
      @(negedge BitCLK);
      Reset = 1'b1;

      // K28.1 stream: only a comma when all K28.x commas are accepted
      apply(mk(10'b000, 3, 0, 0, 0, 0, 0), "k1_idle");
      apply(mk(K1, 10, 0, 0, 0, 0, 0), "k1_0");
      apply(mk(K1, 10, ANY, K1, 1, 0, 0), "k1_1");
      apply(mk(K1, 10, ANY, K1, 1, 0, 0), "k1_2");
      apply(mk(A, 10, ANY, K1, 1, 1'(ANY), 1'(ANY)), "k1_3");
      apply(mk(A, 10, ANY, A, 0, 1'(ANY), 1'(ANY)), "k1_4");

      $display("test done: total=%0d bad=%0d", total, nbad);
      $finish;
   end

endmodule
